// File: rtl/bus_master_port_if.sv
// Requester and arbiter/handshake signals of bus_master_port, grouped as one bundle.
// The "master" modport is the port's own view; "slave" is the environment's view.
interface bus_master_port_if #(
    parameter int ADDRESS_WIDTH  = 15,
    parameter int DATA_WIDTH     = 8,
    parameter int SLAVE_ID_WIDTH = 3
);
    logic                      req;
    logic                      wr_in;
    logic [SLAVE_ID_WIDTH-1:0] slave_id_in;
    logic [ADDRESS_WIDTH-1:0]  addr_in;
    logic [DATA_WIDTH-1:0]     wdata_in;
    logic                      busy;
    logic                      done;
    logic                      err;
    logic [DATA_WIDTH-1:0]     rdata;
    logic                      bus_req;
    logic                      bus_grant;
    logic                      slave_busy;

    modport master (
        input  req, wr_in, slave_id_in, addr_in, wdata_in, bus_grant, slave_busy,
        output busy, done, err, rdata, bus_req
    );

    modport slave (
        output req, wr_in, slave_id_in, addr_in, wdata_in, bus_grant, slave_busy,
        input  busy, done, err, rdata, bus_req
    );
endinterface

// File: rtl/bus_master_port.sv
// Serial bus master: arbitrates, shifts out ID/address/data LSB first, handshakes on slave_busy
// and deserializes read data. Optional parity: define BUS_PARITY_EN (slaves must match).
module bus_master_port #(
    parameter int ADDRESS_WIDTH  = 15,
    parameter int DATA_WIDTH     = 8,
    parameter int SLAVE_ID_WIDTH = 3,
    parameter int ACK_TIMEOUT    = 16
) (
    input  logic               clk,
    input  logic               rstn,
    bus_master_port_if.master  bif,
    output wire                bus_util,
    output wire                rd_wrt,
    inout  wire                data_bus_serial
);
`ifdef BUS_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    localparam int FW   = SLAVE_ID_WIDTH + ADDRESS_WIDTH + DATA_WIDTH;
    localparam int RW   = DATA_WIDTH + PW;
    localparam int M1   = (SLAVE_ID_WIDTH > ADDRESS_WIDTH) ? SLAVE_ID_WIDTH : ADDRESS_WIDTH;
    localparam int MAXF = (M1 > DATA_WIDTH) ? M1 : DATA_WIDTH;
    // One spare code so the response counter can also index a trailing parity bit.
    localparam int CW   = $clog2(MAXF + 1);
    localparam int TW   = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CW-1:0] ID_LAST   = CW'(SLAVE_ID_WIDTH - 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDRESS_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] RD_LAST   = CW'(RW - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_ID, S_ADDR, S_WDATA, S_PAR,
        S_WAIT_ACK, S_WAIT_DONE, S_RDATA, S_FINISH
    } state_t;

    state_t          state;
    logic            wr;
    logic            own;
    logic            dout_en;
    logic [FW-1:0]   frame;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   tcnt;
    logic [RW-1:0]   rsh;
    logic [RW-1:0]   rsh_n;
    logic            busy, done, err, bus_req;
    logic [DATA_WIDTH-1:0] rdata;
`ifdef BUS_PARITY_EN
    logic            par_q;
`endif

    assign bus_util        = own     ? 1'b1     : 1'bz;
    assign rd_wrt          = own     ? wr       : 1'bz;
    assign data_bus_serial = dout_en ? frame[0] : 1'bz;

    assign bif.busy    = busy;
    assign bif.done    = done;
    assign bif.err     = err;
    assign bif.bus_req = bus_req;
    assign bif.rdata   = rdata;

    always_comb begin
        rsh_n      = rsh;
        rsh_n[cnt] = data_bus_serial;
    end

    task finish_txn(input logic fail);
        done    <= ~fail;
        err     <= fail;
        own     <= 1'b0;
        dout_en <= 1'b0;
        busy    <= 1'b0;
        bus_req <= 1'b0;
        state   <= S_FINISH;
    endtask

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            wr      <= 1'b0;
            own     <= 1'b0;
            dout_en <= 1'b0;
            frame   <= '0;
            cnt     <= '0;
            tcnt    <= '0;
            rsh     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            bus_req <= 1'b0;
            rdata   <= '0;
`ifdef BUS_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: if (bif.req) begin
                    wr      <= bif.wr_in;
                    frame   <= {bif.wdata_in, bif.addr_in, bif.slave_id_in};
`ifdef BUS_PARITY_EN
                    par_q   <= bif.wr_in ? ^{bif.wdata_in, bif.addr_in, bif.slave_id_in}
                                         : ^{bif.addr_in, bif.slave_id_in};
`endif
                    busy    <= 1'b1;
                    bus_req <= 1'b1;
                    state   <= S_REQ;
                end
                S_REQ: if (bif.bus_grant) begin
                    own     <= 1'b1;
                    dout_en <= 1'b1;
                    cnt     <= '0;
                    state   <= S_ID;
                end
                S_ID: begin
                    frame <= frame >> 1;
                    if (cnt == ID_LAST) begin
                        cnt   <= '0;
                        state <= S_ADDR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ADDR, S_WDATA: begin
                    frame <= frame >> 1;
                    cnt   <= cnt + 1'b1;
                    if (state == S_ADDR && cnt == ADDR_LAST && wr) begin
                        cnt   <= '0;
                        state <= S_WDATA;
                    end else if ((state == S_ADDR && cnt == ADDR_LAST) ||
                                 (state == S_WDATA && cnt == DATA_LAST)) begin
                        cnt <= '0;
`ifdef BUS_PARITY_EN
                        frame <= {{(FW-1){1'b0}}, par_q};
                        state <= S_PAR;
`else
                        dout_en <= 1'b0;
                        tcnt    <= '0;
                        state   <= S_WAIT_ACK;
`endif
                    end
                end
                S_PAR: begin
                    dout_en <= 1'b0;
                    tcnt    <= '0;
                    state   <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (bif.slave_busy)
                        state <= S_WAIT_DONE;
                    else if (tcnt == TO_LAST)
                        finish_txn(1'b1);
                    else
                        tcnt <= tcnt + 1'b1;
                end
                // Bit 0 of the read response is already on the line when busy drops.
                S_WAIT_DONE: if (!bif.slave_busy) begin
                    if (wr) begin
                        finish_txn(1'b0);
                    end else begin
                        rsh   <= rsh_n;
                        cnt   <= cnt + 1'b1;
                        state <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    rsh <= rsh_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == RD_LAST) begin
`ifdef BUS_PARITY_EN
                        if (^rsh_n) begin
                            finish_txn(1'b1);
                        end else begin
                            rdata <= rsh_n[DATA_WIDTH-1:0];
                            finish_txn(1'b0);
                        end
`else
                        rdata <= rsh_n;
                        finish_txn(1'b0);
`endif
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port: write/read frames, handshake timing, timeout, arbitration, reset abort.
module tb_bus_master_port;
    localparam int AW = 15, DW = 8, IW = 3, TO = 16;
`ifdef BUS_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    localparam int RW = DW + PW;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic s_oe = 1'b0;
    logic s_d = 1'b0;
    wire  bus_util, rd_wrt, data_bus_serial;
    int   ntests = 0;
    int   nfail = 0;

    bus_master_port_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .SLAVE_ID_WIDTH(IW)) bif ();

    bus_master_port #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .SLAVE_ID_WIDTH(IW), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .bif(bif),
        .bus_util(bus_util), .rd_wrt(rd_wrt), .data_bus_serial(data_bus_serial)
    );

    assign data_bus_serial = s_oe ? s_d : 1'bz;
    wire util_z = (bus_util === 1'bz);
    wire rw_z   = (rd_wrt === 1'bz);
    wire dat_z  = (data_bus_serial === 1'bz);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic w, input logic [IW-1:0] id, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        bif.req = 1'b1; bif.wr_in = w; bif.slave_id_in = id; bif.addr_in = a; bif.wdata_in = d;
        @(posedge clk); #1;
        bif.req = 1'b0;
    endtask

    // One REQ cycle with grant already high, then land at the start of ID.
    task automatic through_req(input string tag);
        @(negedge clk);
        chk({tag, "_req_busy"}, bif.busy, 1);
        chk({tag, "_req_breq"}, bif.bus_req, 1);
        chk({tag, "_req_util_z"}, util_z, 1);
        @(posedge clk); #1;
    endtask

    task automatic get_frame(input int n, output logic [31:0] bits, output logic util1,
                             output logic rw1);
        bits = '0;
        util1 = 1'b0;
        rw1 = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bits[i] = data_bus_serial;
            if (i == 0) begin
                util1 = (bus_util === 1'b1);
                rw1   = rd_wrt;
            end
            @(posedge clk); #1;
        end
    endtask

    // Cycle c=1 is the first cycle after the master releases the data line.
    task automatic resp(input int bs, input int bl, input logic ren, input logic [15:0] word,
                        input int ncyc, output int dcyc, output int ecyc, output int dn,
                        output int en, output logic [DW-1:0] rd_d);
        int idx;
        dcyc = 0; ecyc = 0; dn = 0; en = 0; rd_d = '0;
        for (int c = 1; c <= ncyc; c++) begin
            bif.slave_busy = (c >= bs && c < bs + bl);
            idx = c - (bs + bl);
            s_oe = ren && idx >= 0 && idx < RW;
            s_d  = (idx >= 0 && idx < 16) ? word[idx] : 1'b0;
            @(negedge clk);
            if (bif.done) begin dn++; dcyc = c; rd_d = bif.rdata; end
            if (bif.err)  begin en++; ecyc = c; end
            @(posedge clk); #1;
        end
        bif.slave_busy = 1'b0;
        s_oe = 1'b0;
    endtask

    initial begin
        logic [31:0] fb;
        logic u1, rw1;
        int dc, ec, dn, en, bad;
        logic [DW-1:0] rd_d;

        bif.req = 1'b0; bif.wr_in = 1'b0; bif.slave_id_in = '0; bif.addr_in = '0;
        bif.wdata_in = '0; bif.bus_grant = 1'b1; bif.slave_busy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", bif.busy, 0);
        chk("rst_done", bif.done, 0);
        chk("rst_err", bif.err, 0);
        chk("rst_rdata", bif.rdata, 0);
        chk("rst_breq", bif.bus_req, 0);
        chk("rst_util_z", util_z, 1);
        chk("rst_rdwr_z", rw_z, 1);
        chk("rst_data_z", dat_z, 1);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Write 0/0x0005/0xA5, busy from cycle 3 for 3 cycles -> done on cycle 7
        start(1'b1, 3'd0, 15'h0005, 8'hA5);
        through_req("wr");
        get_frame(IW + AW + DW + PW, fb, u1, rw1);
        chk("wr_util", u1, 1);
        chk("wr_rdwr", rw1, 1);
        chk("wr_id", fb[IW-1:0], 0);
        chk("wr_addr", fb[IW+:AW], 15'h0005);
        chk("wr_data", fb[IW+AW+:DW], 8'hA5);
`ifdef BUS_PARITY_EN
        chk("wr_par", fb[IW+AW+DW], 0);
`endif
        chk("wr_release_z", dat_z, 1);
        resp(3, 3, 1'b0, 16'h0, 12, dc, ec, dn, en, rd_d);
        chk("wr_done_cnt", dn, 1);
        chk("wr_done_cyc", dc, 7);
        chk("wr_err_cnt", en, 0);
        chk("wr_util_end_z", util_z, 1);
        chk("wr_busy_end", bif.busy, 0);

        // Read 2/0x0005, busy cycles 1..3, response 0x3C LSB first
        start(1'b0, 3'd2, 15'h0005, 8'h00);
        through_req("rd");
        get_frame(IW + AW + PW, fb, u1, rw1);
        chk("rd_rdwr", rw1, 0);
        chk("rd_id", fb[IW-1:0], 2);
        chk("rd_addr", fb[IW+:AW], 15'h0005);
`ifdef BUS_PARITY_EN
        chk("rd_par", fb[IW+AW], 1);
`endif
        resp(1, 3, 1'b1, 16'h003C, 16, dc, ec, dn, en, rd_d);
        chk("rd_done_cnt", dn, 1);
        chk("rd_done_cyc", dc, 12 + PW);
        chk("rd_rdata_done", rd_d, 8'h3C);
        chk("rd_err_cnt", en, 0);
        chk("rd_rdata_hold", bif.rdata, 8'h3C);

`ifdef BUS_PARITY_EN
        // 0x81 with parity bit 1 is odd overall -> err, rdata keeps 0x3C
        start(1'b0, 3'd2, 15'h0005, 8'h00);
        through_req("pe");
        get_frame(IW + AW + PW, fb, u1, rw1);
        resp(1, 3, 1'b1, 16'h0181, 16, dc, ec, dn, en, rd_d);
        chk("pe_err_cnt", en, 1);
        chk("pe_err_cyc", ec, 13);
        chk("pe_done_cnt", dn, 0);
        chk("pe_rdata_keep", bif.rdata, 8'h3C);
`endif

        // No slave response -> err on cycle TO+1
        start(1'b0, 3'd1, 15'h7FFF, 8'h00);
        through_req("to");
        get_frame(IW + AW + PW, fb, u1, rw1);
        resp(100, 0, 1'b0, 16'h0, 20, dc, ec, dn, en, rd_d);
        chk("to_err_cnt", en, 1);
        chk("to_err_cyc", ec, TO + 1);
        chk("to_done_cnt", dn, 0);
        chk("to_util_z", util_z, 1);
        chk("to_busy", bif.busy, 0);

        // Grant withheld 10 cycles; a second req mid-wait must be ignored
        bif.bus_grant = 1'b0;
        start(1'b1, 3'd5, 15'h1234, 8'h5A);
        bad = 0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 4) begin
                bif.req = 1'b1; bif.addr_in = 15'h7FFF; bif.wdata_in = 8'hFF; bif.slave_id_in = 3'd7;
            end else begin
                bif.req = 1'b0;
            end
            @(negedge clk);
            if (!(bif.bus_req === 1'b1 && bus_util === 1'bz && bif.busy === 1'b1)) bad++;
            @(posedge clk); #1;
        end
        bif.bus_grant = 1'b1;
        @(posedge clk); #1;
        bif.bus_grant = 1'b0;
        chk("gr_wait_viol", bad, 0);
        get_frame(IW + AW + DW + PW, fb, u1, rw1);
        chk("gr_util_after", u1, 1);
        chk("gr_id", fb[IW-1:0], 5);
        chk("gr_addr", fb[IW+:AW], 15'h1234);
        chk("gr_data", fb[IW+AW+:DW], 8'h5A);
        resp(1, 1, 1'b0, 16'h0, 6, dc, ec, dn, en, rd_d);
        chk("gr_done_cnt", dn, 1);
        chk("gr_done_cyc", dc, 3);
        bif.bus_grant = 1'b1;

        // Reset during address shift aborts at once
        start(1'b0, 3'd6, 15'h0F0F, 8'h00);
        through_req("ra");
        get_frame(IW + 5, fb, u1, rw1);
        chk("ra_util_own", u1, 1);
        rstn = 1'b0;
        #1;
        chk("ra_util_z", util_z, 1);
        chk("ra_rdwr_z", rw_z, 1);
        chk("ra_data_z", dat_z, 1);
        chk("ra_busy", bif.busy, 0);
        chk("ra_breq", bif.bus_req, 0);
        chk("ra_rdata", bif.rdata, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        resp(100, 0, 1'b0, 16'h0, 30, dc, ec, dn, en, rd_d);
        chk("ra_no_done", dn, 0);
        chk("ra_no_err", en, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Master-side serial bus interface that feeds the memory slaves on the shared serial bus.
- Accepts one parallel read/write request from a local requester and arbitrates for the bus.
- Serializes slave ID, address and write data onto data_bus_serial, then handshakes on slave_busy.
- For reads, deserializes the returned data and presents it in parallel with a done pulse.

Parameters:
- ADDRESS_WIDTH, 15: address bits sent per transaction.
- DATA_WIDTH, 8: data word width.
- SLAVE_ID_WIDTH, 3: slave ID bits sent at frame start.
- ACK_TIMEOUT, 16: cycles allowed for slave_busy to rise after the last driven bit.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- req  input  1  start transaction; sampled in IDLE only
- wr_in  input  1  1 = write, 0 = read
- slave_id_in  input  SLAVE_ID_WIDTH  target slave
- addr_in  input  ADDRESS_WIDTH  target address
- wdata_in  input  DATA_WIDTH  write data
- busy  output  1  transaction in progress
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle error pulse (timeout)
- rdata  output  DATA_WIDTH  read data, valid when done=1 for a read, then held
- bus_req  output  1  request to arbiter
- bus_grant  input  1  grant from arbiter
- bus_util  output  1  driven 1 while owning the bus, else Z
- rd_wrt  output  1  driven with latched wr_in while owning the bus, else Z
- data_bus_serial  inout  1  serial data line
- slave_busy  input  1  slave handshake (bus pull-down)

Behaviour:
- Reset (async): state=IDLE; busy=0, done=0, err=0, rdata=0, bus_req=0; bus_util, rd_wrt and data_bus_serial all Z. Reset mid-transaction aborts immediately with the same values; no done or err is produced.
- IDLE: when req=1, latch wr_in, slave_id_in, addr_in and wdata_in. Go to REQ with busy=1 and bus_req=1. req is ignored while busy=1.
- REQ: wait for bus_grant=1. The next cycle enters ID and drives bus_util=1 and rd_wrt.
- ID: shift slave ID LSB first, one bit per clk, over SLAVE_ID_WIDTH cycles, then go to ADDR.
- ADDR: shift address LSB first over ADDRESS_WIDTH cycles. For a write, go to WDATA; for a read, go to WAIT_ACK.
- WDATA: shift data LSB first over DATA_WIDTH cycles, then go to WAIT_ACK.
- WAIT_ACK: data_bus_serial released to Z; counter cleared on entry.
  - slave_busy=1 → go to WAIT_DONE.
  - Counter reaches ACK_TIMEOUT with no slave_busy → go to FINISH with err.
- WAIT_DONE: wait, with no timeout, for slave_busy=0.
  - Write → go to FINISH.
  - Read → go to RDATA. The sample of bit 0 occurs in the same cycle slave_busy is seen low.
- RDATA: sample data_bus_serial on DATA_WIDTH consecutive clks, LSB first, into a shift register. Load rdata on the last bit, then go to FINISH.
- FINISH: assert done=1 (or err=1 on timeout) for exactly one cycle.
  - Release bus_util and rd_wrt to Z.
  - Drop bus_req and busy in that cycle; return to IDLE.
- Latency, write with immediate ack, grant already high: 1 (REQ) + SLAVE_ID_WIDTH + ADDRESS_WIDTH + DATA_WIDTH + ack/busy cycles + 1.
- Simultaneous events: bus_grant falling mid-frame is ignored; ownership lasts until FINISH. slave_busy already high on WAIT_ACK entry counts as immediate ack.
- Shift counter width is clog2 of the largest field. Timeout counter saturates.

Optional Feature:
- Macro: BUS_PARITY_EN.
- Defined:
  - Write: one even-parity bit over ID, address and data is sent after the last driven field, before WAIT_ACK.
  - Read: one even-parity bit over ID and address is sent after the address.
  - Read response: one extra bit is sampled after the data. A parity mismatch gives err=1 in FINISH instead of done, and rdata is not updated.
  - Slaves must be built with the same macro.
- Undefined: no parity bits; err arises from timeout only.

Test Plan:
- Write, grant held high, ID=3'd0, addr=15'h0005, data=8'hA5, slave raises busy 2 cycles after release and holds it 3 cycles → data_bus_serial shows 0,0,0, then 1,0,1,0…0, then 1,0,1,0,0,1,0,1; done=1 exactly once; bus_util returns to Z.
- Read, addr=15'h0005, slave busy 1..3 cycles, then returns 8'h3C LSB first → rdata=8'h3C on the done cycle and held afterward.
- No slave response for ACK_TIMEOUT=16 cycles → err=1 pulse on cycle 17 after release; done never asserted; bus released.
- bus_grant withheld 10 cycles after req → bus_req=1 and bus_util=Z throughout; the frame starts the cycle after grant.
- req pulsed again while busy=1 → ignored; latched addr_in and wdata_in unchanged.
- rstn low during ADDR shift → all bus outputs Z and busy=0 immediately. With BUS_PARITY_EN, a read response with a wrong parity bit → err=1 and rdata unchanged.
